// File: rtl/tck_burst_scheduler.sv
// tck_burst_scheduler: issues bursts of an exact number of TCK cycles at a rate set by 'scale'.
// Each TCK phase lasts 256-scale clk_in cycles. Supports free-run and single-step bursts, and
// halt. The tck output and both strobes are registered. 'done' is a one-cycle pulse, raised the
// cycle after the burst's last event.
// Optional build macro: TCK_HEARTBEAT_EN adds a free-running heartbeat square wave.
module tck_burst_scheduler #(
    parameter int CNT_W  = 16,
    parameter int HB_DIV = 2500000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [7:0]       scale,
    input  logic [CNT_W-1:0] cycle_count,
    input  logic             step_mode,
    input  logic             start,
    input  logic             step_req,
    input  logic             halt,
    output logic             tck,
    output logic             tck_rise_stb,
    output logic             tck_fall_stb,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [CNT_W-1:0] cycles_left,
    output logic             heartbeat
);

    typedef enum logic [1:0] {StIdle, StRun, StStepWait, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       scale_q, scale_d;
    logic             step_lat_q, step_lat_d;
    logic             tck_q, tck_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             halted_q, halted_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] cl_q, cl_d;
    logic             halt_eff;

    // A halt pulse is remembered until the burst can honour it.
    assign halt_eff = halt | halt_pend_q;

    // Next-state and registered-output logic for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        scale_d     = scale_q;
        step_lat_d  = step_lat_q;
        tck_d       = tck_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        halted_d    = halted_q;
        halt_pend_d = halt_pend_q;
        cl_d        = cl_q;

        unique case (state_q)
            StIdle: begin
                halt_pend_d = 1'b0;
                if (start) begin
                    scale_d    = scale;
                    step_lat_d = step_mode;
                    cl_d       = cycle_count;
                    presc_d    = scale;
                    halted_d   = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (cycle_count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!tck_q) begin
                    // Low phase: halt is served at once, with no further strobes.
                    if (halt_eff) begin
                        state_d     = StDone;
                        halted_d    = 1'b1;
                        halt_pend_d = 1'b0;
                    end else if (presc_q == 8'hFF) begin
                        presc_d = scale_q;
                        tck_d   = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end else begin
                    // High phase always runs to its falling edge.
                    halt_pend_d = halt_eff;
                    if (presc_q == 8'hFF) begin
                        presc_d = scale_q;
                        tck_d   = 1'b0;
                        fall_d  = 1'b1;
                        cl_d    = cl_q - CNT_W'(1);
                        if (cl_q == CNT_W'(1)) begin
                            // Natural completion beats a coincident halt.
                            state_d     = StDone;
                            halt_pend_d = 1'b0;
                        end else if (halt_eff) begin
                            state_d     = StDone;
                            halted_d    = 1'b1;
                            halt_pend_d = 1'b0;
                        end else if (step_lat_q) begin
                            state_d = StStepWait;
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
            end
            StStepWait: begin
                if (halt_eff) begin
                    state_d     = StDone;
                    halted_d    = 1'b1;
                    halt_pend_d = 1'b0;
                end else if (step_req) begin
                    presc_d = scale_q;
                    state_d = StRun;
                end
            end
            StDone: begin
                halt_pend_d = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= StIdle;
            presc_q     <= 8'd0;
            scale_q     <= 8'd0;
            step_lat_q  <= 1'b0;
            tck_q       <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            cl_q        <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            scale_q     <= scale_d;
            step_lat_q  <= step_lat_d;
            tck_q       <= tck_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            halted_q    <= halted_d;
            halt_pend_q <= halt_pend_d;
            cl_q        <= cl_d;
        end
    end

    assign tck          = tck_q;
    assign tck_rise_stb = rise_q;
    assign tck_fall_stb = fall_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign halted       = halted_q;
    assign cycles_left  = cl_q;

`ifdef TCK_HEARTBEAT_EN
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic        hb_q, hb_d;

    // Heartbeat divider: toggle once every HB_DIV+1 cycles.
    always_comb begin
        hb_cnt_d = hb_cnt_q + 32'd1;
        hb_d     = hb_q;
        if (hb_cnt_q == 32'(HB_DIV)) begin
            hb_cnt_d = 32'd0;
            hb_d     = ~hb_q;
        end
    end

    // Heartbeat register, independent of burst activity.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            hb_cnt_q <= 32'd0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign heartbeat = hb_q;
`else
    // Held low for every legal (non-negative) HB_DIV.
    assign heartbeat = (HB_DIV < 0);
`endif

endmodule

// File: tb/tb_tck_burst_scheduler.sv
// Scoreboard bench for tck_burst_scheduler. Each burst is planned from its timing rules. The plan
// is a list of expected rise, fall and done events, with their cycles. A monitor pops the list
// whenever the DUT raises a strobe or done.
module tb_tck_burst_scheduler;
    localparam int CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       scale = 8'd0;
    logic [CNT_W-1:0] cycle_count = '0;
    logic             step_mode = 1'b0;
    logic             start = 1'b0;
    logic             step_req = 1'b0;
    logic             halt = 1'b0;
    logic             tck, tck_rise_stb, tck_fall_stb, busy, done, halted, heartbeat;
    logic [CNT_W-1:0] cycles_left;

    tck_burst_scheduler #(.CNT_W(CNT_W), .HB_DIV(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .scale       (scale),
        .cycle_count (cycle_count),
        .step_mode   (step_mode),
        .start       (start),
        .step_req    (step_req),
        .halt        (halt),
        .tck         (tck),
        .tck_rise_stb(tck_rise_stb),
        .tck_fall_stb(tck_fall_stb),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .cycles_left (cycles_left),
        .heartbeat   (heartbeat)
    );

    always #5 clk_in = ~clk_in;

    // Number of rising edges so far; outputs sampled at a negedge belong to edge 'cyc'.
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int kind;    // 0 rise, 1 fall, 2 done
        int edge_n;
        int cl;
        bit hlt;
    } ev_t;

    ev_t exp_q[$];
    int  step_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at edge %0d", name, got, want, cyc);
        end
    endtask

    task automatic push(input int k, input int e, input int c, input bit h);
        ev_t x;
        x.kind = k; x.edge_n = e; x.cl = c; x.hlt = h;
        exp_q.push_back(x);
    endtask

    // Plan one burst. a = accept edge, h = halt edge (0 = none). Each phase lasts 256-s cycles.
    task automatic plan(input int a, input int s, input int n, input bit stp, input int h,
                        output int dend);
        int p, t, left, rise, fall, sedge;
        bit fin;
        p = 256 - s; t = a; left = n; fin = 1'b0;
        step_q.delete();
        if (n == 0) begin
            push(2, a + 1, 0, 1'b0);
            dend = a + 1;
            return;
        end
        dend = 0;
        while (!fin) begin
            rise = t + p;
            fall = rise + p;
            if (h > t && h <= rise) begin
                push(2, h + 1, left, 1'b1);
                dend = h + 1; fin = 1'b1;
            end else if (h > rise && h <= fall) begin
                push(0, rise, left, 1'b0);
                left--;
                push(1, fall, left, 1'b0);
                push(2, fall + 1, left, left != 0);
                dend = fall + 1; fin = 1'b1;
            end else begin
                push(0, rise, left, 1'b0);
                left--;
                push(1, fall, left, 1'b0);
                if (left == 0) begin
                    push(2, fall + 1, 0, 1'b0);
                    dend = fall + 1; fin = 1'b1;
                end else if (stp) begin
                    sedge = fall + 1 + int'($urandom_range(0, 6));
                    if (h > fall && h <= sedge) begin
                        push(2, h + 1, left, 1'b1);
                        dend = h + 1; fin = 1'b1;
                    end else begin
                        step_q.push_back(sedge);
                        t = sedge;
                    end
                end else begin
                    t = fall;
                end
            end
        end
    endtask

    // Drive one burst; must be entered at a negedge. Inputs change freely while busy.
    task automatic run_burst(input logic [7:0] s, input int n, input bit stp, input int hrel);
        int a, h, dend;
        bit is_step;
        a = cyc + 1;
        h = (hrel != 0) ? a + hrel : 0;
        plan(a, int'(s), n, stp, h, dend);
        for (int e = a; e <= dend + 1; e++) begin
            if (e == a) begin
                start = 1'b1; scale = s; cycle_count = n[CNT_W-1:0]; step_mode = stp;
            end else begin
                start       = (e <= dend) ? 1'($urandom_range(0, 1)) : 1'b0;
                scale       = 8'($urandom);
                cycle_count = CNT_W'($urandom);
                step_mode   = 1'($urandom_range(0, 1));
            end
            is_step = 1'b0;
            foreach (step_q[i]) if (step_q[i] == e) is_step = 1'b1;
            step_req = is_step;
            halt     = (e == h);
            @(negedge clk_in);
            if (e == a) begin
                chk("accept_busy", busy, 1);
                chk("accept_halted_clear", halted, 0);
            end
        end
        start = 1'b0; step_req = 1'b0; halt = 1'b0;
        @(negedge clk_in);
        chk("burst_events_all_seen", exp_q.size(), 0);
    endtask

    // Monitor: every strobe or done must match the head of the expected list.
    always @(negedge clk_in) begin
        int  nev, kind;
        ev_t x;
        if (mon_en) begin
            nev = int'(tck_rise_stb) + int'(tck_fall_stb) + int'(done);
            kind = done ? 2 : (tck_fall_stb ? 1 : 0);
            if (nev > 1) begin
                chk("event_overlap", nev, 1);
            end else if (nev == 1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_kind", kind, 99);
                end else begin
                    x = exp_q.pop_front();
                    chk("ev_kind", kind, x.kind);
                    chk("ev_edge", cyc, x.edge_n);
                    chk("ev_cycles_left", cycles_left, x.cl);
                    if (kind == 2) begin
                        chk("done_halted", halted, x.hlt);
                        chk("done_busy", busy, 0);
                        chk("done_tck", tck, 0);
                    end else begin
                        chk("strobe_tck_level", tck, (kind == 0) ? 1 : 0);
                    end
                end
            end
        end
    end

`ifdef TCK_HEARTBEAT_EN
    int   hb_last = -1;
    logic hb_prev = 1'b0;
    always @(negedge clk_in) begin
        if (!reset) begin
            hb_last = -1;
            hb_prev = 1'b0;
        end else if (heartbeat !== hb_prev) begin
            if (hb_last >= 0) chk("heartbeat_period", cyc - hb_last, 5);
            hb_last = cyc;
            hb_prev = heartbeat;
        end
    end
`endif

    initial begin
        bit   seen_high;
        int   s, n, hrel;
        bit   stp;
        repeat (3) @(negedge clk_in);
        chk("rst_tck", tck, 0);
        chk("rst_rise", tck_rise_stb, 0);
        chk("rst_fall", tck_fall_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cycles_left", cycles_left, 0);
        chk("rst_heartbeat", heartbeat, 0);
        reset = 1'b1;
        @(negedge clk_in);
        mon_en = 1'b1;

        run_burst(8'hFF, 3, 1'b0, 0);
        run_burst(8'hFC, 2, 1'b0, 0);
        run_burst(8'hFF, 2, 1'b1, 0);
        run_burst(8'hFF, 0, 1'b0, 0);
        run_burst(8'hFF, 10, 1'b0, 8);      // halt in the high phase of the 4th TCK
        run_burst(8'hFF, 5, 1'b0, 0);       // halted must clear on accept
        run_burst(8'hFE, 4, 1'b0, 5);       // halt in a low phase
        run_burst(8'hFF, 3, 1'b1, 3);       // halt while waiting for a step
        run_burst(8'h00, 1, 1'b0, 0);       // slowest rate
        run_burst(8'hFF, 16'hFFFF, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            s    = int'($urandom_range(248, 255));
            n    = int'($urandom_range(0, 6));
            stp  = 1'($urandom_range(0, 1));
            hrel = ($urandom_range(0, 1) == 1) ?
                   int'($urandom_range(1, 2 * n * (256 - s) + 8)) : 0;
            run_burst(8'(s), n, stp, hrel);
        end

        // Reset in the middle of a burst, while tck is high.
        mon_en = 1'b0;
        start = 1'b1; scale = 8'hFF; cycle_count = 16'd20; step_mode = 1'b0;
        @(negedge clk_in);
        start = 1'b0;
        seen_high = 1'b0;
        for (int i = 0; i < 10 && !seen_high; i++) begin
            if (tck === 1'b1) seen_high = 1'b1;
            else @(negedge clk_in);
        end
        chk("midburst_tck_seen_high", seen_high, 1);
        reset = 1'b0; start = 1'b1; scale = 8'h10;
        @(negedge clk_in);
        chk("midrst_tck", tck, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rise", tck_rise_stb, 0);
        chk("midrst_fall", tck_fall_stb, 0);
        chk("midrst_done", done, 0);
        reset = 1'b1; start = 1'b0;
        @(negedge clk_in);
        chk("postrst_done", done, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_cycles_left", cycles_left, 0);
        exp_q.delete();
        mon_en = 1'b1;

        run_burst(8'hFD, 2, 1'b0, 0);
        repeat (4) @(negedge clk_in);
`ifndef TCK_HEARTBEAT_EN
        chk("heartbeat_tied_low", heartbeat, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tck_burst_scheduler.md
Name: tck_burst_scheduler

Overview:
- Sequences the JTAG TCK for the executor: produces bursts of an exact number of TCK cycles at a programmable rate, on request from the scan engine.
- Replaces the free-running TCK divider; TCK phase changes are synchronous to clk_in, and the block supplies single-cycle rise/fall strobes for TDI/TMS launch and TDO capture.
- Supports free-run bursts, a single-step mode (one TCK per operator step request) and a clean halt.

Parameters:
- CNT_W, 16, width of the burst cycle count and the cycles_left output.
- HB_DIV, 2500000, clk_in cycles per heartbeat half-period (used only with the optional feature).

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-low reset, sampled on clk_in.
- scale  in  8  TCK rate; each TCK phase lasts 256-scale clk_in cycles.
- cycle_count  in  CNT_W  number of TCK cycles in the burst.
- step_mode  in  1  1 = single-step burst.
- start  in  1  burst request; level-sampled while idle.
- step_req  in  1  single-cycle pulse that releases one TCK cycle in step mode.
- halt  in  1  abort the burst.
- tck  out  1  registered TCK.
- tck_rise_stb  out  1  one-cycle pulse coincident with tck going high.
- tck_fall_stb  out  1  one-cycle pulse coincident with tck going low.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- halted  out  1  set when the last burst ended by halt; held until the next accepted start.
- cycles_left  out  CNT_W  remaining TCK cycles in the burst.
- heartbeat  out  1  square wave; see Optional Feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; prescaler 0.
- States: IDLE, RUN, STEP_WAIT, DONE.
- IDLE:
  - start=1 accepts a burst: latch scale, cycle_count and step_mode; load the prescaler with the latched scale; clear halted; busy=1.
  - cycle_count=0: go to DONE with no TCK edges.
  - Otherwise go to RUN.
  - halt and step_req are ignored in IDLE.
- RUN, prescaler:
  - Increments each clk_in cycle.
  - At 255 it reloads the latched scale and toggles tck, so each phase lasts 256-scale cycles.
  - First tck rise occurs 256-scale cycles after the accepting edge (scale=FFh gives 1 cycle and a 2-cycle TCK period; scale=00h gives 256 cycles per phase).
- RUN, TCK edges:
  - tck 0→1: assert tck_rise_stb in the same cycle.
  - tck 1→0: assert tck_fall_stb and decrement cycles_left.
  - If cycles_left reaches 0 on a fall, go to DONE.
  - Else, if step_mode is latched, go to STEP_WAIT.
- STEP_WAIT:
  - tck held 0, prescaler frozen.
  - step_req=1 reloads the prescaler with scale and returns to RUN; the next rise follows 256-scale cycles later.
- DONE:
  - done=1 for one cycle, busy=0, tck=0, then IDLE.
  - start may be accepted on the cycle after DONE.
- Latched values: scale, count and step_mode changes during a burst are ignored. start while busy is ignored.
- Halt:
  - In RUN with tck=0, or in STEP_WAIT: go to DONE on the next edge and set halted=1. cycles_left freezes at its current value; no strobes are issued.
  - In RUN with tck=1: complete the high phase normally (fall strobe issued, cycles_left decremented), then go to DONE with halted=1.
  - halt is held internally until it is served, so a single-cycle pulse suffices.
- Simultaneous events:
  - halt and step_req in the same cycle in STEP_WAIT: halt wins.
  - Final fall and halt in the same cycle: normal completion, halted=0.
- Reset mid-burst: immediate return to reset values; no done pulse.
- cycles_left wraps never; a count of 2^CNT_W−1 is legal.

Optional Feature:
- Macro TCK_HEARTBEAT_EN.
- Defined: a free-running counter toggles heartbeat every HB_DIV+1 clk_in cycles, independent of bursts (10 Hz at 50 MHz). The counter is cleared by reset, with heartbeat=0.
- Undefined: heartbeat tied 0 and the counter is not built.

Test Plan:
- scale=FFh, cycle_count=3, step_mode=0, start pulse → tck high 1 cycle after accept; 3 periods of 2 cycles; 3 rise and 3 fall strobes; cycles_left 3→2→1→0; done one cycle after the last fall; busy low from done.
- scale=FCh, cycle_count=2 → each phase 4 cycles; first rise 4 cycles after accept; total burst 16 cycles plus DONE.
- step_mode=1, cycle_count=2, scale=FFh → one TCK, then STEP_WAIT with tck=0 indefinitely; step_req pulse → second TCK 1 cycle later, then done; no TCK without step_req.
- cycle_count=0 → done on the cycle after accept, no strobes, halted=0.
- cycle_count=10, halt pulsed during tck high after 4 rises → that fall completes, cycles_left=6, done and halted=1; next start clears halted.
- reset asserted mid-burst with tck=1 → tck, busy, strobes all 0 next edge, no done; start changes during the burst have no effect. With TCK_HEARTBEAT_EN and HB_DIV=4: heartbeat toggles every 5 cycles.
